// File: rtl/sram_arbiter.sv
// Two-port round-robin arbiter and access sequencer for the external 1Mx16 SRAM.
// Port 0 is the CPU memory path, port 1 a secondary master (loader/debug).
// The FSM state is one cycle ahead of the registered pins, so a grant at edge T
// puts the strobes on the pins for T+1..T+ACCESS_CYCLES and done at T+ACCESS_CYCLES+1.
// Handshake: pN_req is a level sampled only while IDLE; pN_gnt pulses for one
// cycle when the command is latched, and pN_done pulses once when it has finished.
// After pN_gnt the requester may drop req or change its inputs.
module sram_arbiter #(
  parameter int ACCESS_CYCLES = 2
) (
  input  logic        Clk,
  input  logic        Reset_ah,
  input  logic        p0_req,
  input  logic        p0_we,
  input  logic [15:0] p0_addr,
  input  logic [15:0] p0_wdata,
  output logic        p0_gnt,
  output logic        p0_done,
  input  logic        p1_req,
  input  logic        p1_we,
  input  logic [15:0] p1_addr,
  input  logic [15:0] p1_wdata,
  output logic        p1_gnt,
  output logic        p1_done,
  output logic [15:0] rdata,
  output logic        Mem_CE,
  output logic        Mem_UB,
  output logic        Mem_LB,
  output logic        Mem_OE,
  output logic        Mem_WE,
  output logic [19:0] ADDR,
  output logic [15:0] Data_to_SRAM,
  input  logic [15:0] Data_from_SRAM,
  output logic        tristate_oe,
  output logic [1:0]  o_dbg_state
);

  localparam logic [3:0] CNT_LOAD = 4'(ACCESS_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_next_state;
  logic        r_last_grant;
  logic        r_cmd_port;
  logic        r_cmd_we;
  logic [15:0] r_cmd_addr;
  logic [15:0] r_cmd_wdata;
  logic [3:0]  r_counter;

  logic        w_req_any;
  logic        w_pick;
  logic        w_grant;
  logic        w_strobe;
  logic        w_p0_gnt;
  logic        w_p1_gnt;
  logic        w_p0_done;
  logic        w_p1_done;
  logic        w_ce_n;
  logic        w_oe_n;
  logic        w_we_n;
  logic        w_toe;
  logic [19:0] w_addr;
  logic [15:0] w_wdata;
  logic [15:0] w_rdata;

  assign o_dbg_state = r_state;

  // Round-robin pick: on a tie the port that did not win last time goes next.
  always_comb begin
    w_req_any = p0_req | p1_req;
    if (p0_req && p1_req) begin
      w_pick = ~r_last_grant;
    end else begin
      w_pick = p1_req;
    end
    w_grant = (r_state == S_IDLE) && w_req_any;
  end

  // State register.
  always_ff @(posedge Clk) begin
    if (Reset_ah) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state: IDLE -> ACCESS on any request, ACCESS until counter expires, one DONE cycle.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:   if (w_req_any) w_next_state = S_ACCESS;
      S_ACCESS: if (r_counter == 4'd0) w_next_state = S_DONE;
      S_DONE:   w_next_state = S_IDLE;
      default:  w_next_state = S_IDLE;
    endcase
  end

  // Command latch, last-grant memory and access-length counter.
  always_ff @(posedge Clk) begin
    if (Reset_ah) begin
      r_last_grant <= 1'b1;
      r_cmd_port   <= 1'b0;
      r_cmd_we     <= 1'b0;
      r_cmd_addr   <= 16'h0000;
      r_cmd_wdata  <= 16'h0000;
      r_counter    <= 4'd0;
    end else if (w_grant) begin
      r_last_grant <= w_pick;
      r_cmd_port   <= w_pick;
      r_cmd_we     <= w_pick ? p1_we    : p0_we;
      r_cmd_addr   <= w_pick ? p1_addr  : p0_addr;
      r_cmd_wdata  <= w_pick ? p1_wdata : p0_wdata;
      r_counter    <= CNT_LOAD;
    end else if (r_state == S_ACCESS && r_counter != 4'd0) begin
      r_counter <= r_counter - 4'd1;
    end
  end

  // Output decode: next value of every registered pin from the current state.
  always_comb begin
    w_strobe  = (r_state == S_ACCESS);
    w_p0_gnt  = w_grant && !w_pick;
    w_p1_gnt  = w_grant &&  w_pick;
    w_p0_done = (r_state == S_DONE) && !r_cmd_port;
    w_p1_done = (r_state == S_DONE) &&  r_cmd_port;
    w_ce_n    = !w_strobe;
    w_oe_n    = !(w_strobe && !r_cmd_we);
    w_we_n    = !(w_strobe &&  r_cmd_we);
    w_toe     = w_strobe && r_cmd_we;
    w_addr    = w_strobe ? {4'b0000, r_cmd_addr} : ADDR;
    w_wdata   = (w_strobe && r_cmd_we) ? r_cmd_wdata : Data_to_SRAM;
    // Strobes are still low on the pins during the DONE state, so sample here.
    w_rdata   = (r_state == S_DONE && !r_cmd_we) ? Data_from_SRAM : rdata;
  end

  // Output registers.
  always_ff @(posedge Clk) begin
    if (Reset_ah) begin
      p0_gnt       <= 1'b0;
      p1_gnt       <= 1'b0;
      p0_done      <= 1'b0;
      p1_done      <= 1'b0;
      Mem_CE       <= 1'b1;
      Mem_UB       <= 1'b1;
      Mem_LB       <= 1'b1;
      Mem_OE       <= 1'b1;
      Mem_WE       <= 1'b1;
      tristate_oe  <= 1'b0;
      ADDR         <= 20'h00000;
      Data_to_SRAM <= 16'h0000;
      rdata        <= 16'h0000;
    end else begin
      p0_gnt       <= w_p0_gnt;
      p1_gnt       <= w_p1_gnt;
      p0_done      <= w_p0_done;
      p1_done      <= w_p1_done;
      Mem_CE       <= w_ce_n;
      Mem_UB       <= w_ce_n;
      Mem_LB       <= w_ce_n;
      Mem_OE       <= w_oe_n;
      Mem_WE       <= w_we_n;
      tristate_oe  <= w_toe;
      ADDR         <= w_addr;
      Data_to_SRAM <= w_wdata;
      rdata        <= w_rdata;
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: directed scenarios followed by randomized transactions,
// checked against a transaction-level model (round-robin rule, word memory, fixed timing).
module tb_sram_arbiter;

  localparam int AC = 2;

  logic        Clk;
  logic        Reset_ah;
  logic        p0_req, p0_we, p0_gnt, p0_done;
  logic [15:0] p0_addr, p0_wdata;
  logic        p1_req, p1_we, p1_gnt, p1_done;
  logic [15:0] p1_addr, p1_wdata;
  logic [15:0] rdata;
  logic        Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE;
  logic [19:0] ADDR;
  logic [15:0] Data_to_SRAM;
  logic [15:0] Data_from_SRAM;
  logic        tristate_oe;
  logic [1:0]  dbg_state;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic        m_last;
  logic [15:0] m_rdata;
  logic [15:0] ref_mem [0:255];

  // SRAM behavioural model
  logic [15:0] sram_mem [0:255];

  sram_arbiter #(.ACCESS_CYCLES(AC)) dut (
    .Clk(Clk), .Reset_ah(Reset_ah),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_gnt(p0_gnt), .p0_done(p0_done),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_gnt(p1_gnt), .p1_done(p1_done),
    .rdata(rdata),
    .Mem_CE(Mem_CE), .Mem_UB(Mem_UB), .Mem_LB(Mem_LB), .Mem_OE(Mem_OE), .Mem_WE(Mem_WE),
    .ADDR(ADDR), .Data_to_SRAM(Data_to_SRAM), .Data_from_SRAM(Data_from_SRAM),
    .tristate_oe(tristate_oe), .o_dbg_state(dbg_state)
  );

  // Clock
  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  // SRAM: preload, write on clock while CE/WE low, read combinationally while CE/OE low.
  initial begin
    for (int i = 0; i < 256; i++) sram_mem[i] = 16'(i * 37 + 5);
  end

  always @(posedge Clk) begin
    if (!Mem_CE && !Mem_WE) sram_mem[ADDR[7:0]] <= Data_to_SRAM;
  end

  assign Data_from_SRAM = (!Mem_CE && !Mem_OE) ? sram_mem[ADDR[7:0]] : 16'hA5A5;

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic do_reset();
    Reset_ah = 1'b1;
    repeat (2) @(posedge Clk);
    #1;
    Reset_ah = 1'b0;
    m_last   = 1'b1;
    m_rdata  = 16'h0000;
  endtask

  // One complete transaction: drive requests, expect the grant next edge, follow the
  // access cycles and the done cycle against the model.
  task automatic run_txn(input logic r0, input logic r1, input logic we0, input logic we1,
                         input logic [15:0] a0, input logic [15:0] a1,
                         input logic [15:0] d0, input logic [15:0] d1,
                         input logic keep, input string tag);
    int          n;
    logic        port, we;
    logic [15:0] a, d;
    p0_req = r0; p0_we = we0; p0_addr = a0; p0_wdata = d0;
    p1_req = r1; p1_we = we1; p1_addr = a1; p1_wdata = d1;
    port = (r0 && r1) ? ~m_last : r1;
    we   = port ? we1 : we0;
    a    = port ? a1  : a0;
    d    = port ? d1  : d0;
    n = 0;
    do begin
      tick();
      n++;
    end while (!(p0_gnt || p1_gnt) && n < 8);
    chk({tag, "_gnt_latency"}, 32'(n), 32'd1);
    chk({tag, "_gnt"}, 32'({p0_gnt, p1_gnt, p0_done, p1_done}), 32'({!port, port, 2'b00}));
    m_last = port;
    if (!keep) begin
      p0_req = 1'b0; p1_req = 1'b0;
      p0_addr = 16'hFFFF; p1_addr = 16'hFFFF;
      p0_we = ~we0; p1_we = ~we1;
      p0_wdata = 16'($urandom); p1_wdata = 16'($urandom);
    end
    for (int k = 0; k < AC; k++) begin
      tick();
      chk({tag, "_acc_strobes"}, 32'({Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE, tristate_oe}),
          32'({3'b000, we, !we, we}));
      chk({tag, "_acc_addr"}, 32'(ADDR), 32'({4'h0, a}));
      if (we) chk({tag, "_acc_wdata"}, 32'(Data_to_SRAM), 32'(d));
      chk({tag, "_acc_hs"}, 32'({p0_gnt, p1_gnt, p0_done, p1_done}), 32'd0);
    end
    tick();
    chk({tag, "_done_strobes"}, 32'({Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE, tristate_oe}),
        32'(6'b111110));
    chk({tag, "_done_hs"}, 32'({p0_gnt, p1_gnt, p0_done, p1_done}), 32'({2'b00, !port, port}));
    if (we) ref_mem[a[7:0]] = d;
    else    m_rdata = ref_mem[a[7:0]];
    chk({tag, "_rdata"}, 32'(rdata), 32'(m_rdata));
  endtask

  initial begin
    for (int i = 0; i < 256; i++) ref_mem[i] = 16'(i * 37 + 5);
    Reset_ah = 1'b0;
    p0_req = 1'b0; p0_we = 1'b0; p0_addr = 16'h0; p0_wdata = 16'h0;
    p1_req = 1'b0; p1_we = 1'b0; p1_addr = 16'h0; p1_wdata = 16'h0;

    // Reset values
    do_reset();
    chk("rst_strobes", 32'({Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE, tristate_oe}), 32'(6'b111110));
    chk("rst_addr", 32'(ADDR), 32'd0);
    chk("rst_wdata", 32'(Data_to_SRAM), 32'd0);
    chk("rst_rdata", 32'(rdata), 32'd0);
    chk("rst_hs", 32'({p0_gnt, p1_gnt, p0_done, p1_done}), 32'd0);

    // Idle for 10 cycles
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("idle", 32'({Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE, tristate_oe,
                       p0_gnt, p1_gnt, p0_done, p1_done}), 32'(10'b1111100000));
    end

    // Port 0 write, then port 1 reads it back
    run_txn(1'b1, 1'b0, 1'b1, 1'b0, 16'h0042, 16'h0000, 16'hBEEF, 16'h0000, 1'b0, "p0_write");
    run_txn(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0042, 16'h0000, 16'h0000, 1'b0, "p1_read");
    chk("p1_read_beef", 32'(rdata), 32'h0000BEEF);

    // Both requesting continuously from reset: grants alternate, back to back
    p0_req = 1'b1; p1_req = 1'b1;
    do_reset();
    run_txn(1'b1, 1'b1, 1'b1, 1'b0, 16'h0010, 16'h0010, 16'h1111, 16'h0, 1'b1, "rr0");
    run_txn(1'b1, 1'b1, 1'b1, 1'b0, 16'h0011, 16'h0010, 16'h2222, 16'h0, 1'b1, "rr1");
    run_txn(1'b1, 1'b1, 1'b0, 1'b1, 16'h0011, 16'h0012, 16'h0, 16'h3333, 1'b1, "rr2");
    run_txn(1'b1, 1'b1, 1'b0, 1'b0, 16'h0012, 16'h0011, 16'h0, 16'h0, 1'b1, "rr3");
    p0_req = 1'b0; p1_req = 1'b0;
    tick();
    chk("rr_quiet", 32'({p0_gnt, p1_gnt, p0_done, p1_done}), 32'd0);

    // Request dropped and address changed to 0xFFFF after the grant
    run_txn(1'b1, 1'b0, 1'b0, 1'b0, 16'h0005, 16'h0000, 16'h0, 16'h0, 1'b0, "drop_req");

    // Randomized transactions
    for (int i = 0; i < 30; i++) begin
      logic r0, r1;
      r0 = 1'($urandom_range(0, 1));
      r1 = 1'($urandom_range(0, 1));
      if (!r0 && !r1) r0 = 1'b1;
      run_txn(r0, r1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              16'($urandom_range(0, 31)), 16'($urandom_range(0, 31)),
              16'($urandom), 16'($urandom), 1'b0, "rand");
      repeat ($urandom_range(0, 2)) begin
        tick();
        chk("rand_gap", 32'({Mem_CE, Mem_OE, Mem_WE, tristate_oe, p0_gnt, p1_gnt, p0_done, p1_done}),
            32'(8'b11100000));
      end
    end

    // Reset during the second access cycle of a write
    p0_req = 1'b1; p0_we = 1'b1; p0_addr = 16'h0077; p0_wdata = 16'h1234;
    p1_req = 1'b0;
    tick();
    chk("abort_gnt", 32'({p0_gnt, p1_gnt}), 32'(2'b10));
    p0_req = 1'b0;
    tick();
    chk("abort_acc1", 32'({Mem_CE, Mem_WE, tristate_oe}), 32'(3'b001));
    tick();
    chk("abort_acc2", 32'({Mem_CE, Mem_WE, tristate_oe}), 32'(3'b001));
    Reset_ah = 1'b1;
    tick();
    Reset_ah = 1'b0;
    m_last = 1'b1;
    m_rdata = 16'h0000;
    chk("abort_strobes", 32'({Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE, tristate_oe}), 32'(6'b111110));
    chk("abort_hs", 32'({p0_gnt, p1_gnt, p0_done, p1_done}), 32'd0);
    chk("abort_rdata", 32'(rdata), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("abort_quiet", 32'({Mem_CE, p0_gnt, p1_gnt, p0_done, p1_done}), 32'(5'b10000));
    end
    run_txn(1'b1, 1'b1, 1'b0, 1'b0, 16'h0003, 16'h0004, 16'h0, 16'h0, 1'b0, "post_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
